// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the microcode sequencer: widths, the inactive
// control word, control-word bit positions and rom_addr field layout.
package cpu_ctrl_pkg;

  localparam int STEP_BITS = 3;
  localparam int OPC_BITS  = 8;
  localparam int FLAG_BITS = 4;
  localparam int CW_WIDTH  = 32;
  localparam int ADDR_BITS = FLAG_BITS + OPC_BITS + STEP_BITS;

  localparam logic [CW_WIDTH-1:0]  CW_IDLE      = 32'h17FF58FF;
  localparam logic [STEP_BITS-1:0] IR_LOAD_STEP = 3'd1;
  localparam int RSTEP_BIT = 31;
  localparam int HLT_BIT   = 30;

  // rom_addr = {flags, ir, step}
  localparam int ADDR_STEP_LSB  = 0;
  localparam int ADDR_IR_LSB    = ADDR_STEP_LSB + STEP_BITS;
  localparam int ADDR_FLAGS_LSB = ADDR_IR_LSB + OPC_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  function automatic logic [ADDR_BITS-1:0] pack_rom_addr(
    input logic [FLAG_BITS-1:0] flags,
    input logic [OPC_BITS-1:0]  ir,
    input logic [STEP_BITS-1:0] step
  );
    logic [ADDR_BITS-1:0] a;
    a = '0;
    a[ADDR_FLAGS_LSB +: FLAG_BITS] = flags;
    a[ADDR_IR_LSB    +: OPC_BITS]  = ir;
    a[ADDR_STEP_LSB  +: STEP_BITS] = step;
    return a;
  endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// Bundle between the sequencer, the cpu datapath and the microcode ROM.
// master = sequencer side, slave = cpu/ROM side.
interface microcode_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic [OPC_BITS-1:0]  main_bus;
  logic [FLAG_BITS-1:0] flags;
  logic                 run;
  logic                 step_req;
  logic [ADDR_BITS-1:0] rom_addr;
  logic [CW_WIDTH-1:0]  rom_data;
  logic [CW_WIDTH-1:0]  control_word;
  logic                 ctrlen;
  logic [STEP_BITS-1:0] step;
  logic [OPC_BITS-1:0]  ir;
  logic                 halted;
  logic                 ucode_err;

  modport master (
    input  main_bus, flags, run, step_req, rom_data,
    output rom_addr, control_word, ctrlen, step, ir, halted, ucode_err
  );

  modport slave (
    output main_bus, flags, run, step_req, rom_data,
    input  rom_addr, control_word, ctrlen, step, ir, halted, ucode_err
  );

endinterface

// File: rtl/step_counter.sv
// Microstep counter: synchronous clear, hold, increment with natural
// wrap; wrap flags the last step so the caller can detect overrun.
module step_counter
  import cpu_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [STEP_BITS-1:0] count,
  output logic                 wrap
);

  // count register; clear wins over increment, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign wrap = &count;

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: owns IR and the microstep counter, addresses the
// external microcode ROM and gates its word into the cpu.
//
// state    | meaning
// ST_IDLE  | just out of reset, outputs inactive
// ST_RUN   | stepping microcode, ROM word drives the cpu
// ST_PAUSE | stopped at an instruction boundary, outputs inactive
// ST_HALT  | HLT seen, frozen until reset
module microcode_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  microcode_sequencer_if.master   bus
);

  state_t               state, state_nxt;
  logic [STEP_BITS-1:0] step_q;
  logic [OPC_BITS-1:0]  ir_q;
  logic                 err_q;
  logic                 wrap, cnt_clr, cnt_inc, err_set;
  logic                 hlt, rstep;

  assign hlt   = bus.rom_data[HLT_BIT];
  assign rstep = bus.rom_data[RSTEP_BIT];

  step_counter u_step (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (step_q),
    .wrap  (wrap)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state and counter control; HLT outranks RSTEP, and an overrun
  // without RSTEP ends the instruction the same way but flags an error
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = bus.run ? ST_RUN : ST_PAUSE;
      ST_RUN: begin
        if (hlt) begin
          state_nxt = ST_HALT;
        end else if (rstep || wrap) begin
          cnt_clr = 1'b1;
          err_set = !rstep;
          if (!bus.run) state_nxt = ST_PAUSE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_PAUSE: if (bus.step_req || bus.run) state_nxt = ST_RUN;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // opcode fetch: IR captures the bus at the close of the load step
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        ir_q <= '0;
    else if (state == ST_RUN && step_q == IR_LOAD_STEP) ir_q <= bus.main_bus;
  end

  // sticky microcode overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign bus.rom_addr     = pack_rom_addr(bus.flags, ir_q, step_q);
  assign bus.control_word = (state == ST_RUN) ? bus.rom_data : CW_IDLE;
  assign bus.ctrlen       = (state == ST_RUN);
  assign bus.step         = step_q;
  assign bus.ir           = ir_q;
  assign bus.halted       = (state == ST_HALT);
  assign bus.ucode_err    = err_q;

endmodule
